// File: rtl/mam_pkg.sv
// mam_pkg: shared arbiter state type, beat-count width, request record and
// beat-count helpers for the MAM request arbiter.
package mam_pkg;

  localparam int MAM_BEATS_WIDTH = 14;
  localparam int MAM_ADDR_WIDTH  = 32;

  localparam logic [MAM_BEATS_WIDTH-1:0] MAM_BEATS_ONE  = 14'd1;
  localparam logic [MAM_BEATS_WIDTH-1:0] MAM_BEATS_ZERO = 14'd0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  // Request record at the default address width. Packages cannot take
  // parameters, so modules with a different ADDR_WIDTH declare a local twin.
  typedef struct packed {
    logic                       rw;
    logic [MAM_ADDR_WIDTH-1:0]  addr;
    logic                       burst;
    logic [MAM_BEATS_WIDTH-1:0] beats;
  } mam_req_t;

  // Beat count advertised to the bridge: a zero-length burst is promoted to 1.
  function automatic logic [MAM_BEATS_WIDTH-1:0] beats_fwd(
    input logic                       burst,
    input logic [MAM_BEATS_WIDTH-1:0] beats
  );
    if (burst && (beats == MAM_BEATS_ZERO)) begin
      return MAM_BEATS_ONE;
    end else begin
      return beats;
    end
  endfunction

  // Number of data handshakes the transaction will take.
  function automatic logic [MAM_BEATS_WIDTH-1:0] beats_load(
    input logic                       burst,
    input logic [MAM_BEATS_WIDTH-1:0] beats
  );
    if (burst) begin
      return beats_fwd(burst, beats);
    end else begin
      return MAM_BEATS_ONE;
    end
  endfunction

endpackage

// File: rtl/mam_rr_sel.sv
// mam_rr_sel: combinational requester selection. Round-robin search starts
// one past ptr and wraps; in fixed-priority mode the lowest index wins.
module mam_rr_sel #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             fixed_prio,
  output logic [N_REQ-1:0] winner
);

  logic found;
  int   idx;

  // Scan candidates in priority order and keep the first active one.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (fixed_prio) begin
        idx = k;
      end else begin
        idx = (int'(ptr) + k + 32'sd1) % N_REQ;
      end
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mam_req_arb.sv
// mam_req_arb: shares one MAM request/write/read channel set between N_REQ
// requesters. Each transaction is owned atomically by one requester.
// Define MAM_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority;
// otherwise arbitration is round-robin.
module mam_req_arb import mam_pkg::*; #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                            CLK_I,
  input  logic                            RST_I,
  input  logic [N_REQ-1:0]                s_req_valid,
  output logic [N_REQ-1:0]                s_req_ready,
  input  logic [N_REQ-1:0]                s_req_rw,
  input  logic [N_REQ-1:0]                s_req_burst,
  input  logic [N_REQ*ADDR_WIDTH-1:0]     s_req_addr,
  input  logic [N_REQ*MAM_BEATS_WIDTH-1:0] s_req_beats,
  input  logic [N_REQ-1:0]                s_write_valid,
  output logic [N_REQ-1:0]                s_write_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0]     s_write_data,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]   s_write_strb,
  output logic [N_REQ-1:0]                s_read_valid,
  input  logic [N_REQ-1:0]                s_read_ready,
  output logic [DATA_WIDTH-1:0]           s_read_data,
  output logic                            m_req_valid,
  input  logic                            m_req_ready,
  output logic                            m_req_rw,
  output logic [ADDR_WIDTH-1:0]           m_req_addr,
  output logic                            m_req_burst,
  output logic [MAM_BEATS_WIDTH-1:0]      m_req_beats,
  output logic                            m_write_valid,
  input  logic                            m_write_ready,
  output logic [DATA_WIDTH-1:0]           m_write_data,
  output logic [DATA_WIDTH/8-1:0]         m_write_strb,
  input  logic                            m_read_valid,
  output logic                            m_read_ready,
  input  logic [DATA_WIDTH-1:0]           m_read_data,
  output logic [N_REQ-1:0]                gnt
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

`ifdef MAM_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  typedef struct packed {
    logic                       rw;
    logic [ADDR_WIDTH-1:0]      addr;
    logic                       burst;
    logic [MAM_BEATS_WIDTH-1:0] beats;
  } req_t;

  arb_state_e                 state, state_nxt;
  logic [N_REQ-1:0]           gnt_nxt, winner;
  logic [PTR_W-1:0]           ptr, ptr_nxt, owner;
  logic [MAM_BEATS_WIDTH-1:0] cnt, cnt_nxt;
  logic                       rw, rw_nxt;
  logic                       req_hs, data_hs;
  req_t                       sel;

  mam_rr_sel #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_sel (
    .req        (s_req_valid),
    .ptr        (ptr),
    .fixed_prio (FIXED_PRIO),
    .winner     (winner)
  );

  // Encode the registered one-hot grant into an owner index.
  always_comb begin
    owner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        owner = PTR_W'(i);
      end else begin
        owner = owner;
      end
    end
  end

  // Pick the owner's request fields out of the packed request buses.
  always_comb begin
    sel.rw    = s_req_rw[owner];
    sel.burst = s_req_burst[owner];
    sel.addr  = s_req_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
    sel.beats = s_req_beats[owner*MAM_BEATS_WIDTH +: MAM_BEATS_WIDTH];
  end

  // Route the owner's channels to the bridge; non-owners see idle handshakes.
  always_comb begin
    s_req_ready   = '0;
    s_write_ready = '0;
    s_read_valid  = '0;
    m_req_valid   = 1'b0;
    m_req_rw      = 1'b0;
    m_req_addr    = '0;
    m_req_burst   = 1'b0;
    m_req_beats   = '0;
    m_write_valid = 1'b0;
    m_write_data  = '0;
    m_write_strb  = '0;
    m_read_ready  = 1'b0;
    case (state)
      ARB_REQ: begin
        m_req_valid        = s_req_valid[owner];
        m_req_rw           = sel.rw;
        m_req_addr         = sel.addr;
        m_req_burst        = sel.burst;
        m_req_beats        = beats_fwd(sel.burst, sel.beats);
        s_req_ready[owner] = m_req_ready;
      end
      ARB_DATA: begin
        if (rw) begin
          m_write_valid        = s_write_valid[owner];
          m_write_data         = s_write_data[owner*DATA_WIDTH +: DATA_WIDTH];
          m_write_strb         = s_write_strb[owner*STRB_W +: STRB_W];
          s_write_ready[owner] = m_write_ready;
        end else begin
          s_read_valid[owner] = m_read_valid;
          m_read_ready        = s_read_ready[owner];
        end
      end
      default: begin
        m_req_valid = 1'b0;
      end
    endcase
  end

  assign s_read_data = m_read_data;
  assign req_hs      = m_req_valid & m_req_ready;
  assign data_hs     = rw ? (m_write_valid & m_write_ready) : (s_read_valid[owner] & m_read_ready);

  // Next-state logic: grant in IDLE, load beats on request handshake, count beats.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    rw_nxt    = rw;
    case (state)
      ARB_IDLE: begin
        if (|s_req_valid) begin
          gnt_nxt   = winner;
          state_nxt = ARB_REQ;
        end else begin
          gnt_nxt = '0;
        end
      end
      ARB_REQ: begin
        if (req_hs) begin
          cnt_nxt   = beats_load(sel.burst, sel.beats);
          rw_nxt    = sel.rw;
          state_nxt = ARB_DATA;
        end else begin
          state_nxt = ARB_REQ;
        end
      end
      ARB_DATA: begin
        if (data_hs) begin
          if (cnt == MAM_BEATS_ONE) begin
            state_nxt = ARB_IDLE;
            gnt_nxt   = '0;
            ptr_nxt   = owner;
            cnt_nxt   = MAM_BEATS_ZERO;
          end else begin
            cnt_nxt = cnt - MAM_BEATS_ONE;
          end
        end else begin
          state_nxt = ARB_DATA;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      ptr   <= PTR_RST;
      cnt   <= MAM_BEATS_ZERO;
      rw    <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      rw    <= rw_nxt;
    end
  end

endmodule

// File: tb/tb_mam_req_arb.sv
// tb_mam_req_arb: randomized requesters and bridge against a transaction-level
// reference model of ownership, grant order and beat counts (N_REQ=3).
module tb_mam_req_arb;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int BW = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_req_valid, s_req_ready, s_req_rw, s_req_burst;
  logic [N*AW-1:0] s_req_addr;
  logic [N*BW-1:0] s_req_beats;
  logic [N-1:0]    s_write_valid, s_write_ready;
  logic [N*DW-1:0] s_write_data;
  logic [N*SW-1:0] s_write_strb;
  logic [N-1:0]    s_read_valid, s_read_ready;
  logic [DW-1:0]   s_read_data;
  logic            m_req_valid, m_req_ready, m_req_rw, m_req_burst;
  logic [AW-1:0]   m_req_addr;
  logic [BW-1:0]   m_req_beats;
  logic            m_write_valid, m_write_ready;
  logic [DW-1:0]   m_write_data;
  logic [SW-1:0]   m_write_strb;
  logic            m_read_valid, m_read_ready;
  logic [DW-1:0]   m_read_data;
  logic [N-1:0]    gnt;

  mam_req_arb #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK_I(clk), .RST_I(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_rw(s_req_rw),
    .s_req_burst(s_req_burst), .s_req_addr(s_req_addr), .s_req_beats(s_req_beats),
    .s_write_valid(s_write_valid), .s_write_ready(s_write_ready),
    .s_write_data(s_write_data), .s_write_strb(s_write_strb),
    .s_read_valid(s_read_valid), .s_read_ready(s_read_ready), .s_read_data(s_read_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_rw(m_req_rw),
    .m_req_addr(m_req_addr), .m_req_burst(m_req_burst), .m_req_beats(m_req_beats),
    .m_write_valid(m_write_valid), .m_write_ready(m_write_ready),
    .m_write_data(m_write_data), .m_write_strb(m_write_strb),
    .m_read_valid(m_read_valid), .m_read_ready(m_read_ready), .m_read_data(m_read_data),
    .gnt(gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    logic          burst;
    logic [BW-1:0] beats;
    logic [AW-1:0] addr;
  } txn_t;

  int   n_checks = 0;
  int   n_errors = 0;
  txn_t pend[N];
  bit   pend_v[N];
  int   own, last, left, n_txn, n_rst;
  bit   in_data, m_rw;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Arbitration rule: fixed lowest index, or first active after the last owner.
  function automatic int pick(input logic [N-1:0] v, input int prev);
`ifdef MAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(prev + k) % N]) return (prev + k) % N;
`endif
    return -1;
  endfunction

  function automatic int beats_of(input txn_t t);
    if (!t.burst) return 1;
    if (t.beats == 14'd0) return 1;
    return int'(t.beats);
  endfunction

  task automatic check_quiet(input string tag);
    check_val({tag, "_gnt"}, 64'(gnt), 64'd0);
    check_val({tag, "_mreqv"}, 64'(m_req_valid), 64'd0);
    check_val({tag, "_sreqr"}, 64'(s_req_ready), 64'd0);
    check_val({tag, "_mwv"}, 64'(m_write_valid), 64'd0);
    check_val({tag, "_swr"}, 64'(s_write_ready), 64'd0);
    check_val({tag, "_srv"}, 64'(s_read_valid), 64'd0);
    check_val({tag, "_mrr"}, 64'(m_read_ready), 64'd0);
  endtask

  task automatic drive_zero();
    s_req_valid = '0; s_req_rw = '0; s_req_burst = '0; s_req_addr = '0; s_req_beats = '0;
    s_write_valid = '0; s_write_data = '0; s_write_strb = '0; s_read_ready = '0;
    m_req_ready = 1'b0; m_write_ready = 1'b0; m_read_valid = 1'b0; m_read_data = '0;
  endtask

  initial begin
    logic [N-1:0] exp_oh;
    bit           in_req, wr_ph, rd_ph, hs;
    rst = 1'b1;
    drive_zero();
    own = -1; last = N - 1; in_data = 1'b0; m_rw = 1'b0; left = 0; n_txn = 0; n_rst = 0;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    #3;
    check_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      // requesters: create work, drive request/data channels
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 2) != 0)) begin
          pend[i].rw    = 1'($urandom_range(0, 1));
          pend[i].burst = 1'($urandom_range(0, 1));
          pend[i].beats = 14'($urandom_range(0, 5));
          pend[i].addr  = 32'($urandom);
          pend_v[i]     = 1'b1;
        end
        if (pend_v[i]) begin
          if (own == i) s_req_valid[i] = !in_data;
          else          s_req_valid[i] = ($urandom_range(0, 3) != 0);
          s_req_rw[i]                = pend[i].rw;
          s_req_burst[i]             = pend[i].burst;
          s_req_beats[i*BW +: BW]    = pend[i].beats;
          s_req_addr[i*AW +: AW]     = pend[i].addr;
        end else begin
          s_req_valid[i]             = 1'b0;
          s_req_rw[i]                = 1'($urandom_range(0, 1));
          s_req_burst[i]             = 1'($urandom_range(0, 1));
          s_req_beats[i*BW +: BW]    = 14'($urandom);
          s_req_addr[i*AW +: AW]     = 32'($urandom);
        end
        s_write_valid[i]          = 1'($urandom_range(0, 1));
        s_write_data[i*DW +: DW]  = DW'($urandom);
        s_write_strb[i*SW +: SW]  = SW'($urandom);
        s_read_ready[i]           = 1'($urandom_range(0, 1));
      end
      m_req_ready   = ($urandom_range(0, 2) != 0);
      m_write_ready = ($urandom_range(0, 2) != 0);
      m_read_valid  = 1'($urandom_range(0, 1));
      m_read_data   = DW'($urandom);

      if (c > 50 && $urandom_range(0, 299) == 0) begin
        // asynchronous reset mid-stream: everything drops to idle at once
        rst = 1'b1;
        #1;
        check_quiet("midrst");
        n_rst++;
        if (own >= 0) pend_v[own] = 1'b0;
        own = -1; last = N - 1; in_data = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_req_valid = '0;
        continue;
      end

      #4;
      exp_oh = (own >= 0) ? N'(1 << own) : '0;
      in_req = (own >= 0) && !in_data;
      wr_ph  = (own >= 0) && in_data && m_rw;
      rd_ph  = (own >= 0) && in_data && !m_rw;
      check_val("gnt", 64'(gnt), 64'(exp_oh));
      check_val("m_req_valid", 64'(m_req_valid), 64'(in_req));
      if (in_req) begin
        check_val("m_req_addr", 64'(m_req_addr), 64'(pend[own].addr));
        check_val("m_req_rw", 64'(m_req_rw), 64'(pend[own].rw));
        check_val("m_req_burst", 64'(m_req_burst), 64'(pend[own].burst));
        check_val("m_req_beats", 64'(m_req_beats),
                  (pend[own].burst && pend[own].beats == 14'd0) ? 64'd1 : 64'(pend[own].beats));
      end
      check_val("s_req_ready", 64'(s_req_ready), (in_req && m_req_ready) ? 64'(exp_oh) : 64'd0);
      check_val("m_write_valid", 64'(m_write_valid), wr_ph ? 64'(s_write_valid[own]) : 64'd0);
      if (wr_ph && s_write_valid[own]) begin
        check_val("m_write_data", 64'(m_write_data), 64'(s_write_data[own*DW +: DW]));
        check_val("m_write_strb", 64'(m_write_strb), 64'(s_write_strb[own*SW +: SW]));
      end
      check_val("s_write_ready", 64'(s_write_ready), (wr_ph && m_write_ready) ? 64'(exp_oh) : 64'd0);
      check_val("s_read_valid", 64'(s_read_valid), (rd_ph && m_read_valid) ? 64'(exp_oh) : 64'd0);
      check_val("m_read_ready", 64'(m_read_ready), rd_ph ? 64'(s_read_ready[own]) : 64'd0);
      check_val("s_read_data", 64'(s_read_data), 64'(m_read_data));

      // advance the reference model across the coming clock edge
      if (own < 0) begin
        if (s_req_valid != '0) begin
          own = pick(s_req_valid, last);
          in_data = 1'b0;
        end
      end else if (!in_data) begin
        if (m_req_ready) begin
          left    = beats_of(pend[own]);
          m_rw    = pend[own].rw;
          in_data = 1'b1;
        end
      end else begin
        hs = m_rw ? (s_write_valid[own] && m_write_ready) : (m_read_valid && s_read_ready[own]);
        if (hs) begin
          left--;
          if (left == 0) begin
            pend_v[own] = 1'b0;
            last        = own;
            own         = -1;
            in_data     = 1'b0;
            n_txn++;
          end
        end
      end
    end

    check_val("txn_progress", 64'(n_txn > 100), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
